// File: rtl/fifo_serializer.sv
// Drains datawidth-bit FIFO words as lanewidth-bit lanes, least significant lane first.
// Define FIFO_SER_PARITY_EN to add the out_parity port (XOR of out_data).
module fifo_serializer #(
   parameter int datawidth = 32,
   parameter int lanewidth = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   output logic                 fifo_cs,
   output logic                 fifo_ren,
   input  logic [datawidth-1:0] fifo_dout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [lanewidth-1:0] out_data,
   output logic                 out_last,
`ifdef FIFO_SER_PARITY_EN
   output logic                 out_parity,
`endif
   output logic                 busy
);

   localparam int Lanes = datawidth / lanewidth;
   localparam int CntW  = $clog2(Lanes);
   localparam logic [CntW-1:0] LastCnt = CntW'(Lanes - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [datawidth-1:0]   sh_q, sh_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   hs;
   logic                   last_hs;

   assign out_valid = (state_q == SEND);
   assign busy      = (state_q != IDLE);
   assign out_data  = sh_q[lanewidth-1:0];
   assign out_last  = out_valid & (cnt_q == LastCnt);
   assign hs        = out_valid & out_ready;
   assign last_hs   = hs & out_last;
   assign fifo_cs   = fifo_ren;

`ifdef FIFO_SER_PARITY_EN
   assign out_parity = ^out_data;
`endif

   // Reads only start from IDLE or on the final-lane handshake; gated by reset.
   always_comb begin
      fifo_ren = 1'b0;
      unique case (state_q)
         IDLE:    fifo_ren = ~fifo_empty;
         SEND:    fifo_ren = last_hs & ~fifo_empty;
         default: fifo_ren = 1'b0;
      endcase
      fifo_ren = fifo_ren & rst;
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (fifo_ren) state_d = LOAD;
         end
         LOAD: begin
            sh_d    = fifo_dout;
            cnt_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            if (hs) begin
               if (out_last) begin
                  state_d = fifo_ren ? LOAD : IDLE;
               end else begin
                  sh_d  = sh_q >> lanewidth;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_serializer.sv
// Testbench for fifo_serializer: upstream FIFO model plus lane-stream scoreboard.
// Parity checks are active when FIFO_SER_PARITY_EN is defined.
module tb_fifo_serializer;

   localparam int DW = 32;
   localparam int LW = 8;
   localparam int LN = DW / LW;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_empty;
   logic          fifo_cs;
   logic          fifo_ren;
   logic [DW-1:0] fifo_dout;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] out_data;
   logic          out_last;
   logic          busy;
`ifdef FIFO_SER_PARITY_EN
   logic          out_parity;
`endif

   fifo_serializer #(
      .datawidth(DW),
      .lanewidth(LW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_empty(fifo_empty),
      .fifo_cs(fifo_cs),
      .fifo_ren(fifo_ren),
      .fifo_dout(fifo_dout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
`ifdef FIFO_SER_PARITY_EN
      .out_parity(out_parity),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LW-1:0] d;
      bit            last;
   } lane_t;

   typedef struct {
      logic [DW-1:0] w;
      logic [LW-1:0] l [LN];
   } vec_t;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] fq [$];
   lane_t         eq [$];

   int            cyc, n_hs, n_ren, first_hs, last_hs, first_ren;
   logic [LW-1:0] hs_dat [$];
   logic [LW-1:0] ren_lane [$];

   bit            s_hs, s_last, s_ren, s_busy, s_valid, s_cs;
   logic [LW-1:0] s_d;
   bit            stall;
   logic [LW-1:0] prev_d;
   bit            prev_last;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fq.push_back(w);
      for (int i = 0; i < LN; i++)
         eq.push_back('{d: w[i*LW +: LW], last: (i == LN - 1)});
   endtask

   task automatic push_vec(input vec_t v);
      fq.push_back(v.w);
      for (int i = 0; i < LN; i++)
         eq.push_back('{d: v.l[i], last: (i == LN - 1)});
   endtask

   task automatic clr_stats();
      cyc = 0;
      n_hs = 0;
      n_ren = 0;
      first_hs = -1;
      last_hs = -1;
      first_ren = -1;
      hs_dat.delete();
      ren_lane.delete();
   endtask

   // One clock: drive inputs at negedge, sample, score, then model FIFO read data.
   task automatic step(input bit rdy);
      lane_t         e;
      bit            pend;
      logic [DW-1:0] pw;
      pend = 1'b0;
      pw = '0;
      @(negedge clk);
      out_ready = rdy;
      fifo_empty = (fq.size() == 0);
      #1;
      s_valid = out_valid;
      s_hs = out_valid && out_ready;
      s_d = out_data;
      s_last = out_last;
      s_ren = fifo_ren;
      s_cs = fifo_cs;
      s_busy = busy;
      chk("cs_eq_ren", s_cs, s_ren);
      if (stall) begin
         chk("hold_valid", s_valid, 1);
         chk("hold_data", s_d, prev_d);
         chk("hold_last", s_last, prev_last);
      end
      stall = s_valid && !rdy;
      prev_d = s_d;
      prev_last = s_last;
`ifdef FIFO_SER_PARITY_EN
      if (s_valid) chk("parity", out_parity, ^s_d);
      if (s_hs && s_d == 8'h07) chk("parity_07", out_parity, 1);
      if (s_hs && s_d == 8'h03) chk("parity_03", out_parity, 0);
`endif
      if (s_hs) begin
         n_hs++;
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         hs_dat.push_back(s_d);
         if (eq.size() == 0) begin
            chk("unexpected_lane", 1, 0);
         end else begin
            e = eq.pop_front();
            chk("lane_data", s_d, e.d);
            chk("lane_last", s_last, e.last);
         end
      end
      if (s_ren) begin
         n_ren++;
         if (first_ren < 0) first_ren = cyc;
         if (s_hs) ren_lane.push_back(s_d);
         chk("ren_legal", (!s_busy) || (s_hs && s_last), 1);
         if (fq.size() == 0) begin
            chk("ren_on_empty", 1, 0);
         end else begin
            pend = 1'b1;
            pw = fq.pop_front();
         end
      end
      cyc++;
      @(posedge clk);
      #1;
      fifo_dout = pend ? pw : DW'($urandom());
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (eq.size() == 0) break;
         step(1'b1);
      end
      chk("drain_left", eq.size(), 0);
   endtask

   task automatic reset_check(input string tag);
      @(negedge clk);
      #2;
      fifo_empty = 1'b0;
      rst = 1'b0;
      #1;
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ren"}, fifo_ren, 0);
      chk({tag, "_cs"}, fifo_cs, 0);
      repeat (2) @(posedge clk);
      fq.delete();
      eq.delete();
      stall = 1'b0;
      @(negedge clk);
      fifo_empty = 1'b1;
      rst = 1'b1;
   endtask

   vec_t tv [4];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      out_ready = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout = '0;
      stall = 1'b0;
      tv[0].w = 32'h44332211; tv[0].l = '{8'h11, 8'h22, 8'h33, 8'h44};
      tv[1].w = 32'hDDCCBBAA; tv[1].l = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      tv[2].w = 32'h80FF0001; tv[2].l = '{8'h01, 8'h00, 8'hFF, 8'h80};
      tv[3].w = 32'h12345678; tv[3].l = '{8'h78, 8'h56, 8'h34, 8'h12};

      repeat (2) @(posedge clk);
      reset_check("rst0");

      // Empty upstream: nothing may move.
      clr_stats();
      for (int i = 0; i < 10; i++) begin
         step(1'($urandom_range(1)));
         chk("empty_ren", s_ren, 0);
         chk("empty_cs", s_cs, 0);
         chk("empty_valid", s_valid, 0);
         chk("empty_busy", s_busy, 0);
      end

      // Single words from the table.
      foreach (tv[k]) begin
         clr_stats();
         push_vec(tv[k]);
         drain(20);
         chk("tv_nhs", n_hs, LN);
         chk("tv_consecutive", last_hs - first_hs, LN - 1);
         step(1'b1);
         chk("tv_idle_busy", s_busy, 0);
         chk("tv_idle_valid", s_valid, 0);
      end

      // Back-to-back words.
      clr_stats();
      push_word(32'hA3A2A1A0);
      push_word(32'hB3B2B1B0);
      drain(30);
      chk("b2b_nhs", n_hs, 2 * LN);
      chk("b2b_nren", n_ren, 2);
      chk("b2b_ren_mid", ren_lane.size(), 1);
      chk("b2b_ren_a3", ren_lane.size() > 0 ? ren_lane[0] : 8'hxx, 8'hA3);
      chk("b2b_window", last_hs - first_ren, 2 * LN + 2);

      // Backpressure on the second lane with another word queued.
      clr_stats();
      push_word(32'h44332211);
      push_word(32'h55667788);
      repeat (3) step(1'b1);
      chk("bp_first", hs_dat.size() > 0 ? hs_dat[0] : 8'hxx, 8'h11);
      for (int i = 0; i < 5; i++) begin
         step(1'b0);
         chk("bp_valid", s_valid, 1);
         chk("bp_data", s_d, 8'h22);
         chk("bp_last", s_last, 0);
         chk("bp_ren", s_ren, 0);
      end
      drain(30);
      chk("bp_nren", n_ren, 2);

      // Reset after the 0x22 handshake.
      clr_stats();
      push_word(32'h44332211);
      repeat (4) step(1'b1);
      chk("mid_22", hs_dat.size() > 1 ? hs_dat[1] : 8'hxx, 8'h22);
      reset_check("rst_mid");
      clr_stats();
      push_word(32'hDDCCBBAA);
      drain(20);
      chk("mid_first_aa", hs_dat.size() > 0 ? hs_dat[0] : 8'hxx, 8'hAA);
      chk("mid_nhs", n_hs, LN);

      // Parity lanes 0x07 and 0x03.
      clr_stats();
      push_word(32'h00000307);
      drain(20);

      // Randomized traffic with random backpressure and gaps.
      clr_stats();
      begin
         int pushed;
         pushed = 0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0 && pushed < 40) begin
               push_word(DW'($urandom()));
               pushed++;
            end
            step($urandom_range(9) < 7);
         end
         drain(400);
         chk("rand_nhs", n_hs, pushed * LN);
         chk("rand_nren", n_ren, pushed);
      end
      step(1'b1);
      chk("rand_idle", s_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
